vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen_sync_delay.sv | 32 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 1280x800 @ 60 Hz display path.
// The draw stage imports the coordinate widths from here.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 1280;
  localparam int unsigned VGA_H_FP     = 64;
  localparam int unsigned VGA_H_SYNC   = 136;
  localparam int unsigned VGA_H_BP     = 200;
  localparam int unsigned VGA_V_ACTIVE = 800;
  localparam int unsigned VGA_V_FP     = 1;
  localparam int unsigned VGA_V_SYNC   = 3;
  localparam int unsigned VGA_V_BP     = 24;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit VGA_H_POL = 1'b0;
  localparam bit VGA_V_POL = 1'b1;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int RGB_W = 4;

  // Raw or delayed timing flags travelling down the delay line together.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-coordinate / colour bus between the timing generator and the draw stage.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [X_W-1:0]   draw_x;
  logic [Y_W-1:0]   draw_y;
  logic [RGB_W-1:0] draw_r;
  logic [RGB_W-1:0] draw_g;
  logic [RGB_W-1:0] draw_b;

  modport master (output draw_x, draw_y, input draw_r, draw_g, draw_b);
  modport slave  (input draw_x, draw_y, output draw_r, draw_g, draw_b);
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// WIDTH x DEPTH shift register with synchronous active-low clear.
// DEPTH of 0 degenerates to a wire so callers need no special case.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_line
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is cleared, not just the last: a stale sync bit left
    // mid-line would otherwise emerge as a partial pulse after reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator and VGA output stage: scan counters, sync/blank
// decode, draw-latency delay line, blanked colour register and frame tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          H_POL    = VGA_H_POL,
  parameter bit          V_POL    = VGA_V_POL,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic             clk_83,
  input  logic             rst_n,
  vga_timing_gen_if.master draw,
  output logic [RGB_W-1:0] vga_r,
  output logic [RGB_W-1:0] vga_g,
  output logic [RGB_W-1:0] vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             frame_tick,
  output logic             active
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_PRE_BLK = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] hcount;
  logic [Y_W-1:0] vcount;
  timing_t        raw;
  timing_t        dly;
  timing_t        line_q;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the hcount wrap test and the vcount update see the same hcount.
  always_ff @(posedge clk_83) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  assign draw.draw_x = hcount;
  assign draw.draw_y = vcount;

  assign raw.de = (hcount < H_ACT_END) && (vcount < V_ACT_END);
  assign raw.hs = (hcount >= HS_START) && (hcount < HS_END);
  assign raw.vs = (vcount >= VS_START) && (vcount < VS_END);

  // Matches the draw-stage latency; the register below adds the final stage.
  sync_delay #(
    .WIDTH (TIMING_W),
    .DEPTH (int'(PIPE_DLY))
  ) u_sync_delay (
    .clk   (clk_83),
    .rst_n (rst_n),
    .d     (raw),
    .q     (dly)
  );

  always_ff @(posedge clk_83) begin
    if (!rst_n) begin
      line_q     <= '0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      frame_tick <= 1'b0;
    end else begin
      line_q <= dly;
      if (dly.de) begin
        vga_r <= draw.draw_r;
        vga_g <= draw.draw_g;
        vga_b <= draw.draw_b;
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
      // Registered one clock early so the pulse lands on (0, V_ACTIVE).
      frame_tick <= (hcount == H_LAST) && (vcount == V_PRE_BLK);
    end
  end

  assign active = line_q.de;
  assign vga_hs = line_q.hs ? H_POL : ~H_POL;
  assign vga_vs = line_q.vs ? V_POL : ~V_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed + randomised bench for vga_timing_gen: three reduced-geometry
// instances (PIPE_DLY 0/1/3) and one full 1280x800 instance against a cycle-index model.
module tb_vga_timing_gen;

  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic clk;
  logic rst_n;
  bit   mode;
  int   k;
  int   checks;
  int   errors;

  bit   track;
  int   tick_k1[$];
  int   nz1;
  int   first_nz1;
  int   fall_kd;
  int   low_d0;
  int   low_d1;
  logic prev_hsd;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if3 ();
  vga_timing_gen_if ifd ();

  logic [3:0] r0, g0, b0, r1, g1, b1, r3, g3, b3, rd, gd, bd;
  logic hs0, vs0, tk0, ac0, hs1, vs1, tk1, ac1;
  logic hs3, vs3, tk3, ac3, hsd, vsd, tkd, acd;

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .H_POL(1'b0), .V_POL(1'b1), .PIPE_DLY(0)) u0 (
    .clk_83(clk), .rst_n(rst_n), .draw(if0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .vga_hs(hs0), .vga_vs(vs0), .frame_tick(tk0), .active(ac0));

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .H_POL(1'b0), .V_POL(1'b1), .PIPE_DLY(1)) u1 (
    .clk_83(clk), .rst_n(rst_n), .draw(if1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1), .frame_tick(tk1), .active(ac1));

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .H_POL(1'b0), .V_POL(1'b1), .PIPE_DLY(3)) u3 (
    .clk_83(clk), .rst_n(rst_n), .draw(if3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .vga_hs(hs3), .vga_vs(vs3), .frame_tick(tk3), .active(ac3));

  vga_timing_gen ud (
    .clk_83(clk), .rst_n(rst_n), .draw(ifd), .vga_r(rd), .vga_g(gd), .vga_b(bd),
    .vga_hs(hsd), .vga_vs(vsd), .frame_tick(tkd), .active(acd));

  // Draw-stage stand-ins: constant white, or x[3:0] delayed by PIPE_DLY.
  logic [3:0] dl1;
  logic [3:0] dl3 [3];

  always @(posedge clk) begin
    dl1    <= if1.draw_x[3:0];
    dl3[0] <= if3.draw_x[3:0];
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
  end

  assign if0.draw_r = mode ? if0.draw_x[3:0]  : 4'hF;
  assign if0.draw_g = mode ? ~if0.draw_x[3:0] : 4'hF;
  assign if0.draw_b = mode ? if0.draw_x[3:0]  : 4'hF;
  assign if1.draw_r = mode ? dl1    : 4'hF;
  assign if1.draw_g = mode ? ~dl1   : 4'hF;
  assign if1.draw_b = mode ? dl1    : 4'hF;
  assign if3.draw_r = mode ? dl3[2]  : 4'hF;
  assign if3.draw_g = mode ? ~dl3[2] : 4'hF;
  assign if3.draw_b = mode ? dl3[2]  : 4'hF;
  assign ifd.draw_r = 4'hF;
  assign ifd.draw_g = 4'hF;
  assign ifd.draw_b = 4'hF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from k = clocks since reset release: the scan
  // position is k mod the frame, and every pin shows the position D+1 ago.
  task automatic chk(input string nm, input int ha, hf, hsw, hb, va, vf, vsw, vb, d,
                     input bit md, input logic [10:0] x, input logic [9:0] y,
                     input logic [3:0] r, g, b, input logic hs, vs, tk, ac);
    int ht, vt, ex, ey, p, px, py;
    bit de, hsr, vsr;
    logic [3:0]  pl;
    logic [11:0] rgb_e;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ex = k % ht;
    ey = (k / ht) % vt;
    p  = k - (d + 1);
    de = 1'b0; hsr = 1'b0; vsr = 1'b0; pl = 4'h0;
    if (p >= 0) begin
      px  = p % ht;
      py  = (p / ht) % vt;
      de  = (px < ha) && (py < va);
      hsr = (px >= ha + hf) && (px < ha + hf + hsw);
      vsr = (py >= va + vf) && (py < va + vf + vsw);
      pl  = 4'(px);
    end
    rgb_e = !de ? 12'h000 : (md ? {pl, ~pl, pl} : 12'hFFF);
    check({nm, ".draw_x"}, 32'(x), 32'(ex));
    check({nm, ".draw_y"}, 32'(y), 32'(ey));
    check({nm, ".rgb"}, 32'({r, g, b}), 32'(rgb_e));
    check({nm, ".hs"}, 32'(hs), 32'(!hsr));
    check({nm, ".vs"}, 32'(vs), 32'(vsr));
    check({nm, ".active"}, 32'(ac), 32'(de));
    check({nm, ".tick"}, 32'(tk), 32'((ex == 0) && (ey == va)));
  endtask

  task automatic check_all();
    chk("d0", SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 0, mode,
        if0.draw_x, if0.draw_y, r0, g0, b0, hs0, vs0, tk0, ac0);
    chk("d1", SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, mode,
        if1.draw_x, if1.draw_y, r1, g1, b1, hs1, vs1, tk1, ac1);
    chk("d3", SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 3, mode,
        if3.draw_x, if3.draw_y, r3, g3, b3, hs3, vs3, tk3, ac3);
    chk("full", 1280, 64, 136, 200, 800, 1, 3, 24, 1, 1'b0,
        ifd.draw_x, ifd.draw_y, rd, gd, bd, hsd, vsd, tkd, acd);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      k = 0;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    check_all();
    if (track) begin
      if (tk1 === 1'b1) tick_k1.push_back(k);
      if (k <= SHT * SVT + 1 && {r1, g1, b1} !== 12'h000) nz1++;
      if (first_nz1 < 0 && {r1, g1, b1} !== 12'h000) first_nz1 = k;
      if (fall_kd < 0 && prev_hsd === 1'b1 && hsd === 1'b0) fall_kd = k;
      if (hsd === 1'b0 && k < 1680) low_d0++;
      if (hsd === 1'b0 && k >= 1680 && k < 3360) low_d1++;
      prev_hsd = hsd;
    end
  endtask

  initial begin
    int n2;
    checks = 0; errors = 0; k = 0;
    mode = 1'b0; rst_n = 1'b1;
    nz1 = 0; first_nz1 = -1; fall_kd = -1; low_d0 = 0; low_d1 = 0;

    // Constant white: frame period, tick, blanking window, full-size hsync.
    do_reset(3);
    prev_hsd = hsd;
    track = 1'b1;
    repeat (3400) step();
    track = 1'b0;
    n2 = 0;
    foreach (tick_k1[i]) if (tick_k1[i] <= 2 * SHT * SVT) n2++;
    check("tick_count_2frames", 32'(n2), 32'd2);
    check("tick_gap", (tick_k1.size() >= 2) ? 32'(tick_k1[1] - tick_k1[0]) : 32'hFFFF_FFFF,
          32'(SHT * SVT));
    check("nonzero_per_frame", 32'(nz1), 32'(SHA * SVA));
    check("first_nonzero_k", 32'(first_nz1), 32'd2);
    check("hs_fall_k", 32'(fall_kd), 32'd1346);
    check("hs_low_line0", 32'(low_d0), 32'd136);
    check("hs_low_line1", 32'(low_d1), 32'd136);

    // x-pattern colour: per-instance alignment for PIPE_DLY 0, 1 and 3.
    mode = 1'b1;
    do_reset(1);
    repeat (2 * SHT * SVT + 20) step();

    // Random reset lengths and run lengths, then a one-clock reset inside
    // both raw syncs, after which the scan must resume cleanly.
    repeat (4) begin
      do_reset(int'($urandom_range(1, 3)));
      repeat (int'($urandom_range(10, 400))) step();
    end
    do_reset(1);
    repeat ((SVA + SVF) * SHT + SHA + SHF + 1) step();
    check("pre_reset_x", 32'(if1.draw_x), 32'(SHA + SHF + 1));
    check("pre_reset_y", 32'(if1.draw_y), 32'(SVA + SVF));
    do_reset(1);
    check("mid_reset_hs_idle", 32'(hs1), 32'd1);
    check("mid_reset_vs_idle", 32'(vs1), 32'd0);
    repeat (SHT * SVT + 10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
